// File: rtl/lane_sched_tx.sv
// Round-robin scheduler sharing one byte channel between four transmit lanes.
// Sends a comma training burst after reset or retrain, then grants one valid lane per cycle.
module lane_sched_tx #(
    parameter int unsigned N_TRAIN = 4,
    parameter logic [7:0]  COMMA   = 8'hBC,
    parameter logic [7:0]  IDLE    = 8'h7C
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       enable,
    input  logic       retrain,
    input  logic [3:0] valid_in,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    output logic [3:0] ready_out,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] lane_out,
    output logic       active_out
);

    localparam int CNT_W = (N_TRAIN > 1) ? $clog2(N_TRAIN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TRAIN - 1);

    typedef enum logic {
        TRAIN  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] train_cnt, cnt_nxt;
    logic [1:0]       ptr, ptr_nxt;

    logic [7:0]       data_p1, data_nxt;
    logic             vld_p1, vld_nxt;
    logic [1:0]       lane_p1, lane_nxt;
    logic             act_p1, act_nxt;

    logic             grant_found;
    logic [1:0]       grant_lane;
    logic             grant_en;
    logic             xfer;
    logic [7:0]       lane_data;

    // Returns {found, lane}: first valid lane scanning start, start+1, ... mod 4.
    function automatic logic [2:0] pick_lane(input logic [3:0] vin, input logic [1:0] start);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (vin[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    // Stage p0: combinational grant and lane select
    always_comb begin
        {grant_found, grant_lane} = pick_lane(valid_in, ptr);
        grant_en  = (state == ACTIVE) && enable && !retrain && !reset;
        xfer      = grant_en && grant_found;
        ready_out = xfer ? (4'b0001 << grant_lane) : 4'b0000;
        unique case (grant_lane)
            2'd0:    lane_data = data_in0;
            2'd1:    lane_data = data_in1;
            2'd2:    lane_data = data_in2;
            default: lane_data = data_in3;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = train_cnt;
        ptr_nxt   = ptr;
        data_nxt  = data_p1;
        vld_nxt   = vld_p1;
        lane_nxt  = lane_p1;
        act_nxt   = act_p1;
        if (retrain) begin
            state_nxt = TRAIN;
            cnt_nxt   = '0;
            act_nxt   = 1'b0;
            data_nxt  = COMMA;
            vld_nxt   = 1'b0;
        end else begin
            case (state)
                TRAIN: begin
                    data_nxt = COMMA;
                    vld_nxt  = 1'b0;
                    cnt_nxt  = train_cnt + CNT_W'(1);
                    if (train_cnt == CNT_LAST) begin
                        state_nxt = ACTIVE;
                        act_nxt   = 1'b1;
                        cnt_nxt   = '0;
                    end
                end
                ACTIVE: begin
                    if (xfer) begin
                        data_nxt = lane_data;
                        vld_nxt  = 1'b1;
                        lane_nxt = grant_lane;
                        ptr_nxt  = grant_lane + 2'd1;
                    end else begin
                        data_nxt = IDLE;
                        vld_nxt  = 1'b0;
                    end
                end
                default: state_nxt = TRAIN;
            endcase
        end
    end

    // Stage p1: registered state and serializer byte
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state     <= TRAIN;
            train_cnt <= '0;
            ptr       <= 2'd0;
            data_p1   <= 8'h00;
            vld_p1    <= 1'b0;
            lane_p1   <= 2'd0;
            act_p1    <= 1'b0;
        end else begin
            state     <= state_nxt;
            train_cnt <= cnt_nxt;
            ptr       <= ptr_nxt;
            data_p1   <= data_nxt;
            vld_p1    <= vld_nxt;
            lane_p1   <= lane_nxt;
            act_p1    <= act_nxt;
        end
    end

    assign data_out   = data_p1;
    assign valid_out  = vld_p1;
    assign lane_out   = lane_p1;
    assign active_out = act_p1;

endmodule

// File: tb/tb_lane_sched_tx.sv
// Directed table-driven bench for lane_sched_tx: training, round-robin, wrap, enable, retrain, reset.
module tb_lane_sched_tx;

    logic       clk_4f = 1'b0;
    logic       reset, enable, retrain;
    logic [3:0] valid_in;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic [3:0] ready_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_out;
    logic       active_out;

    int checks = 0;
    int errors = 0;

    lane_sched_tx dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .enable    (enable),
        .retrain   (retrain),
        .valid_in  (valid_in),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_in3  (data_in3),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_out  (lane_out),
        .active_out(active_out)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic       rst;
        logic       en;
        logic       rt;
        logic [3:0] vin;
        logic [7:0] d2;
        logic [3:0] rdy;
        logic [7:0] dout;
        logic       vld;
        logic [1:0] lane;
        logic       act;
    } vec_t;

    vec_t tbl[$];
    vec_t seq[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic rt,
                                input logic [3:0] vin, input logic [7:0] d2,
                                input logic [3:0] rdy, input logic [7:0] dout,
                                input logic vld, input logic [1:0] lane, input logic act);
        vec_t v;
        v.rst = rst; v.en = en; v.rt = rt; v.vin = vin; v.d2 = d2;
        v.rdy = rdy; v.dout = dout; v.vld = vld; v.lane = lane; v.act = act;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Inputs applied after negedge; ready sampled before the edge, registers #1 after it.
    task automatic run_vec(input vec_t v, input string tag);
        reset    = v.rst;
        enable   = v.en;
        retrain  = v.rt;
        valid_in = v.vin;
        data_in2 = v.d2;
        #2;
        chk({tag, ".ready_out"}, {4'h0, ready_out}, {4'h0, v.rdy});
        @(posedge clk_4f);
        #1;
        chk({tag, ".data_out"},   data_out, v.dout);
        chk({tag, ".valid_out"},  {7'h0, valid_out}, {7'h0, v.vld});
        chk({tag, ".lane_out"},   {6'h0, lane_out}, {6'h0, v.lane});
        chk({tag, ".active_out"}, {7'h0, active_out}, {7'h0, v.act});
        @(negedge clk_4f);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; retrain = 1'b0; valid_in = 4'h0;
        data_in0 = 8'h11; data_in1 = 8'h22; data_in2 = 8'h33; data_in3 = 8'h44;

        //             rst en rt vin    d2     rdy   dout   vld lane act
        // reset, then training burst and first idle
        tbl.push_back(mk(1, 1, 0, 4'h0, 8'h33, 4'h0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 8'h33, 4'h0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 8'h33, 4'h0, 8'hBC, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h0, 8'h33, 4'h0, 8'h7C, 0, 0, 1));
        // all lanes valid: round robin 0,1,2,3,0 then 1,2 to park ptr at 3
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h1, 8'h11, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h2, 8'h22, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h4, 8'h33, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h8, 8'h44, 1, 3, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h1, 8'h11, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h2, 8'h22, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h4, 8'h33, 1, 2, 1));
        // ptr=3, only lane 2 valid: wraps and is granted every cycle
        tbl.push_back(mk(0, 1, 0, 4'h4, 8'h33, 4'h4, 8'h33, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 4'h4, 8'h35, 4'h4, 8'h35, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 4'h4, 8'h36, 4'h4, 8'h36, 1, 2, 1));
        // move ptr to 1, then enable=0 for 3 cycles
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h8, 8'h44, 1, 3, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h1, 8'h11, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'hF, 8'h33, 4'h0, 8'h7C, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'hF, 8'h33, 4'h0, 8'h7C, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'hF, 8'h33, 4'h0, 8'h7C, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h2, 8'h22, 1, 1, 1));
        // retrain with lane 1 valid (ptr=2 held across training)
        tbl.push_back(mk(0, 1, 1, 4'h2, 8'h33, 4'h0, 8'hBC, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'h2, 8'h33, 4'h0, 8'hBC, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'h2, 8'h33, 4'h0, 8'hBC, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'h2, 8'h33, 4'h0, 8'hBC, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'h2, 8'h33, 4'h0, 8'hBC, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h4, 8'h33, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 4'h2, 8'h33, 4'h2, 8'h22, 1, 1, 1));
        // reset mid-stream with all lanes valid, training restarts
        tbl.push_back(mk(1, 1, 0, 4'hF, 8'h33, 4'h0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h1, 8'h11, 1, 0, 1));

        @(negedge clk_4f);
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

        // retrain in ACTIVE, again mid-burst (count restarts), then reset beating retrain
        seq.push_back(mk(0, 1, 1, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        seq.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        seq.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        seq.push_back(mk(0, 1, 1, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        seq.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        seq.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        seq.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 0));
        seq.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h0, 8'hBC, 0, 0, 1));
        seq.push_back(mk(0, 1, 0, 4'hF, 8'h33, 4'h2, 8'h22, 1, 1, 1));
        seq.push_back(mk(1, 1, 1, 4'hF, 8'h33, 4'h0, 8'h00, 0, 0, 0));
        foreach (seq[i]) run_vec(seq[i], $sformatf("s%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
